// File: rtl/limbus_cpu_dbg_cmd_sync.sv
// Limbus CPU debug command stage: resynchronises JTAG update toggles into clk and issues per-channel strobes.
// Optional even-parity check on jdo[DATA_W-1] is enabled by defining LIMBUS_DBG_CMD_PARITY_EN.
//   state | meaning
//   IDLE  | waiting for an update-DR edge; pending IR updates applied here
//   ISSUE | command word captured, strobe decided this cycle
//   WAIT  | take_action held until act_ready or timeout
module limbus_cpu_dbg_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int ACT_BIT     = 34,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 udr_tgl,
    input  logic                 uir_tgl,
    input  logic [IR_W-1:0]      ir_async,
    input  logic [DATA_W-1:0]    sr_async,
    input  logic [(2**IR_W)-1:0] act_ready,
    input  logic                 clr_status,
    output logic [DATA_W-1:0]    jdo,
    output logic [IR_W-1:0]      ir_q,
    output logic [(2**IR_W)-1:0] take_action,
    output logic [(2**IR_W)-1:0] take_no_action,
    output logic                 overrun,
    output logic                 timeout_err,
    output logic                 parity_err,
    output logic [15:0]          cmd_count
);
    localparam int N_CH = 2**IR_W;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t state, state_d;

    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_hist, uir_hist;
    logic                   udr_edge, uir_edge;
    logic                   par_fail;

    logic [IR_W-1:0]   ch_q, ch_d, ir_d;
    logic              ir_pend, pend_d;
    logic [DATA_W-1:0] jdo_d;
    logic [N_CH-1:0]   ta_d, tna_d;
    logic [TW-1:0]     wait_cnt, wait_d;
    logic              ovr_set, to_set, par_set, cnt_inc;

    // Sync chains carry no reset; hist follows sync_out even in reset so release never shows an edge.
    always_ff @(posedge clk) begin
        udr_sync <= {udr_sync[SYNC_STAGES-2:0], udr_tgl};
        uir_sync <= {uir_sync[SYNC_STAGES-2:0], uir_tgl};
        udr_hist <= udr_sync[SYNC_STAGES-1];
        uir_hist <= uir_sync[SYNC_STAGES-1];
    end

    assign udr_edge = udr_sync[SYNC_STAGES-1] != udr_hist;
    assign uir_edge = uir_sync[SYNC_STAGES-1] != uir_hist;

`ifdef LIMBUS_DBG_CMD_PARITY_EN
    assign par_fail = ^jdo;
`else
    assign par_fail = 1'b0;
`endif

    always_comb begin
        state_d = state;
        ch_d    = ch_q;
        ir_d    = ir_q;
        pend_d  = ir_pend;
        jdo_d   = jdo;
        ta_d    = take_action;
        tna_d   = '0;
        wait_d  = wait_cnt;
        ovr_set = 1'b0;
        to_set  = 1'b0;
        par_set = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                pend_d = 1'b0;
                if (uir_edge || ir_pend) begin
                    ir_d = ir_async;
                end
                if (udr_edge) begin
                    jdo_d   = sr_async;
                    ch_d    = (uir_edge || ir_pend) ? ir_async : ir_q;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (uir_edge) pend_d = 1'b1;
                if (udr_edge) ovr_set = 1'b1;
                wait_d = WAIT_LOAD;
                if (par_fail) begin
                    par_set = 1'b1;
                    state_d = IDLE;
                end else if (!jdo[ACT_BIT]) begin
                    tna_d   = N_CH'(1) << ch_q;
                    cnt_inc = 1'b1;
                    state_d = IDLE;
                end else begin
                    ta_d    = N_CH'(1) << ch_q;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (uir_edge) pend_d = 1'b1;
                if (udr_edge) ovr_set = 1'b1;
                // An accept on the last permitted cycle beats the timeout.
                if (|(take_action & act_ready)) begin
                    ta_d    = '0;
                    cnt_inc = 1'b1;
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt == '0)) begin
                    ta_d    = '0;
                    to_set  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_cnt - TW'(1);
                end
            end
            default: begin
                ta_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ch_q           <= '0;
            ir_q           <= '0;
            ir_pend        <= 1'b0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            wait_cnt       <= '0;
            overrun        <= 1'b0;
            timeout_err    <= 1'b0;
            parity_err     <= 1'b0;
            cmd_count      <= '0;
        end else begin
            state          <= state_d;
            ch_q           <= ch_d;
            ir_q           <= ir_d;
            ir_pend        <= pend_d;
            jdo            <= jdo_d;
            take_action    <= ta_d;
            take_no_action <= tna_d;
            wait_cnt       <= wait_d;
            // A set event coinciding with clr_status survives the clear.
            if (clr_status) begin
                overrun     <= ovr_set;
                timeout_err <= to_set;
                parity_err  <= par_set;
                cmd_count   <= {15'd0, cnt_inc};
            end else begin
                overrun     <= overrun | ovr_set;
                timeout_err <= timeout_err | to_set;
                parity_err  <= parity_err | par_set;
                if (cnt_inc && (cmd_count != 16'hFFFF)) begin
                    cmd_count <= cmd_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_limbus_cpu_dbg_cmd_sync.sv
// Self-checking bench for limbus_cpu_dbg_cmd_sync: randomized commands against a transaction-level model.
// Honours LIMBUS_DBG_CMD_PARITY_EN for the parity case.
module tb_limbus_cpu_dbg_cmd_sync;
    localparam int DATA_W  = 38;
    localparam int IR_W    = 2;
    localparam int N_CH    = 4;
    localparam int ACT_BIT = 34;
    localparam int TIMEOUT = 8;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              udr_tgl    = 1'b0;
    logic              uir_tgl    = 1'b0;
    logic [IR_W-1:0]   ir_async   = '0;
    logic [DATA_W-1:0] sr_async   = '0;
    logic [N_CH-1:0]   act_ready  = '0;
    logic              clr_status = 1'b0;
    logic [DATA_W-1:0] jdo;
    logic [IR_W-1:0]   ir_q;
    logic [N_CH-1:0]   take_action, take_no_action;
    logic              overrun, timeout_err, parity_err;
    logic [15:0]       cmd_count;

    int total = 0;
    int bad   = 0;

    logic [15:0]     exp_cnt = '0;
    logic            exp_ovr = 1'b0;
    logic            exp_to  = 1'b0;
    logic            exp_par = 1'b0;
    logic [IR_W-1:0] exp_ir  = '0;

    limbus_cpu_dbg_cmd_sync #(
        .DATA_W(DATA_W), .IR_W(IR_W), .ACT_BIT(ACT_BIT), .SYNC_STAGES(2), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .udr_tgl(udr_tgl), .uir_tgl(uir_tgl),
        .ir_async(ir_async), .sr_async(sr_async), .act_ready(act_ready),
        .clr_status(clr_status), .jdo(jdo), .ir_q(ir_q), .take_action(take_action),
        .take_no_action(take_no_action), .overrun(overrun), .timeout_err(timeout_err),
        .parity_err(parity_err), .cmd_count(cmd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bump();
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic check_status();
        chk("cmd_count", 64'(cmd_count), 64'(exp_cnt));
        chk("overrun", 64'(overrun), 64'(exp_ovr));
        chk("timeout_err", 64'(timeout_err), 64'(exp_to));
        chk("parity_err", 64'(parity_err), 64'(exp_par));
        chk("ir_q", 64'(ir_q), 64'(exp_ir));
    endtask

    function automatic logic [DATA_W-1:0] fix_par(input logic [DATA_W-1:0] sr);
        logic [DATA_W-1:0] r;
        r = sr;
`ifdef LIMBUS_DBG_CMD_PARITY_EN
        r[DATA_W-1] = ^r[DATA_W-2:0];
`endif
        return r;
    endfunction

    task automatic do_uir(input logic [IR_W-1:0] ir);
        ir_async = ir;
        uir_tgl  = ~uir_tgl;
        repeat (4) cyc();
        exp_ir = ir;
        check_status();
    endtask

    // One command from an idle block: toggle at sample 0, jdo at sample 3, strobe from sample 4.
    // d = samples after the first take_action sample before act_ready[ch] is raised.
    task automatic run_cmd(input logic [DATA_W-1:0] sr, input int d, input logic use_clr);
        logic            act;
        int              len;
        logic [IR_W-1:0] ch;
        logic [N_CH-1:0] oh;
        ch  = exp_ir;
        oh  = N_CH'(1) << ch;
        act = sr[ACT_BIT];
        len = !act ? 1 : ((d < TIMEOUT) ? d + 1 : TIMEOUT);
        sr_async = sr;
        udr_tgl  = ~udr_tgl;
        for (int s = 1; s <= len + 5; s++) begin
            cyc();
            if (s == 4) begin
                if (use_clr) begin
                    exp_cnt = '0;
                    exp_ovr = 1'b0;
                    exp_to  = 1'b0;
                    exp_par = 1'b0;
                end
                if (!act) bump();
            end
            if (act && (s == 4 + len)) begin
                if (d < TIMEOUT) bump();
                else exp_to = 1'b1;
            end
            if (s == 3) chk("jdo", 64'(jdo), 64'(sr));
            chk("take_action", 64'(take_action),
                64'((act && s >= 4 && s < 4 + len) ? oh : {N_CH{1'b0}}));
            chk("take_no_action", 64'(take_no_action),
                64'((!act && s == 4) ? oh : {N_CH{1'b0}}));
            check_status();
            clr_status = use_clr && (s == 3);
            act_ready  = N_CH'($urandom()) & ~oh;
            if (s < 3) act_ready[ch] = 1'($urandom_range(0, 1));
            else act_ready[ch] = act && (s >= 4 + d);
        end
        act_ready  = '0;
        clr_status = 1'b0;
    endtask

    initial begin
        logic [63:0]       r;
        logic [DATA_W-1:0] sr1, sr2;
        logic [IR_W-1:0]   irn;
        logic [N_CH-1:0]   oh;

        repeat (3) cyc();
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_take_action", 64'(take_action), 64'd0);
        chk("rst_take_no_action", 64'(take_no_action), 64'd0);
        check_status();
        reset = 1'b0;
        repeat (2) cyc();

        do_uir(2'b01);
        run_cmd(fix_par(38'h0_0000_1234), 0, 1'b0);
        do_uir(2'b11);
        run_cmd(fix_par(38'h4_0000_00AB), 5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) do_uir(IR_W'($urandom_range(0, N_CH - 1)));
            r = {$urandom(), $urandom()};
            run_cmd(fix_par(r[DATA_W-1:0]), int'($urandom_range(0, TIMEOUT + 3)), 1'b0);
        end

        // Two no-action updates two cycles apart, same word
        sr1 = fix_par(38'h0_0000_5555);
        oh  = N_CH'(1) << exp_ir;
        sr_async = sr1;
        udr_tgl  = ~udr_tgl;
        cyc();
        cyc();
        udr_tgl = ~udr_tgl;
        for (int s = 3; s <= 9; s++) begin
            cyc();
            if (s == 4 || s == 6) bump();
            if (s == 3) chk("b2b_jdo", 64'(jdo), 64'(sr1));
            chk("b2b_take_no_action", 64'(take_no_action),
                64'((s == 4 || s == 6) ? oh : {N_CH{1'b0}}));
            chk("b2b_take_action", 64'(take_action), 64'd0);
            check_status();
        end

        // Action left to time out, with udr and uir toggles landing during WAIT
        sr1 = fix_par(38'h4_1234_5678);
        sr2 = fix_par(38'h0_0FED_CBA9);
        irn = exp_ir + IR_W'(1);
        oh  = N_CH'(1) << exp_ir;
        sr_async = sr1;
        udr_tgl  = ~udr_tgl;
        for (int s = 1; s <= 16; s++) begin
            cyc();
            if (s == 8)  exp_ovr = 1'b1;
            if (s == 12) exp_to  = 1'b1;
            if (s == 13) exp_ir  = irn;
            chk("ovr_take_action", 64'(take_action),
                64'((s >= 4 && s < 4 + TIMEOUT) ? oh : {N_CH{1'b0}}));
            chk("ovr_take_no_action", 64'(take_no_action), 64'd0);
            if (s >= 3) chk("ovr_jdo", 64'(jdo), 64'(sr1));
            check_status();
            if (s == 5) begin
                sr_async = sr2;
                udr_tgl  = ~udr_tgl;
                ir_async = irn;
                uir_tgl  = ~uir_tgl;
            end
        end

        // clr_status on the same edge as a no-action issue
        run_cmd(fix_par(38'h0_0000_0077), 0, 1'b1);

`ifdef LIMBUS_DBG_CMD_PARITY_EN
        sr_async = 38'h1_0000_0000;
        udr_tgl  = ~udr_tgl;
        for (int s = 1; s <= 6; s++) begin
            cyc();
            if (s == 4) exp_par = 1'b1;
            chk("par_take_action", 64'(take_action), 64'd0);
            chk("par_take_no_action", 64'(take_no_action), 64'd0);
            check_status();
        end
`else
        run_cmd(38'h1_0000_0000, 0, 1'b0);
`endif
        clr_status = 1'b1;
        cyc();
        clr_status = 1'b0;
        exp_cnt = '0;
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
        exp_par = 1'b0;
        check_status();

        // Reset while in WAIT with both toggles at 1
        if (uir_tgl == 1'b0) do_uir(exp_ir);
        if (udr_tgl == 1'b1) run_cmd(fix_par(38'h0_0000_0011), 0, 1'b0);
        oh = N_CH'(1) << exp_ir;
        sr_async = fix_par(38'h4_0000_0022);
        udr_tgl  = ~udr_tgl;
        for (int s = 1; s <= 6; s++) begin
            cyc();
            chk("rw_take_action", 64'(take_action), 64'((s >= 4) ? oh : {N_CH{1'b0}}));
        end
        reset = 1'b1;
        cyc();
        exp_cnt = '0;
        exp_ovr = 1'b0;
        exp_to  = 1'b0;
        exp_par = 1'b0;
        exp_ir  = '0;
        chk("rw_take_action_drop", 64'(take_action), 64'd0);
        chk("rw_jdo", 64'(jdo), 64'd0);
        check_status();
        repeat (2) cyc();
        reset = 1'b0;
        for (int s = 0; s < 12; s++) begin
            cyc();
            chk("post_rst_take_action", 64'(take_action), 64'd0);
            chk("post_rst_take_no_action", 64'(take_no_action), 64'd0);
            check_status();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/limbus_cpu_dbg_cmd_sync.md
# limbus_cpu_dbg_cmd_sync

Parametrised system-clock command stage for the Limbus CPU debug path. It takes the JTAG-side shift register, IR value and update events as asynchronous inputs. Update events arrive as toggles, and the block resynchronises them into `clk`. It decodes each update into per-channel action or no-action strobes, and holds every action until the addressed target accepts it. It replaces the fixed 2-bit-IR / 38-bit decode with configurable width, channel count, handshaking, timeout and status reporting.

## Interface
- `DATA_W`, 38: command word width (`sr_async`, `jdo`).
- `IR_W`, 2: IR width. Channel count is `N_CH = 2**IR_W`.
- `ACT_BIT`, 34: bit of `jdo` that selects action (1) or no-action (0). Range `0..DATA_W-2`.
- `SYNC_STAGES`, 2: synchronizer flops per toggle input. Minimum 2.
- `TIMEOUT`, 255: maximum cycles to wait for `act_ready`. 0 disables the timeout.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `udr_tgl` input 1: async toggle. JTAG side inverts it on each update-DR.
- `uir_tgl` input 1: async toggle. JTAG side inverts it on each update-IR.
- `ir_async` input IR_W: IR value, stable from the `uir_tgl` toggle until the next IR scan.
- `sr_async` input DATA_W: shift register, stable from the `udr_tgl` toggle until the next capture.
- `act_ready` input N_CH: per-channel accept for `take_action`.
- `clr_status` input 1: clears the sticky flags and `cmd_count`.
- `jdo` output DATA_W: captured command word.
- `ir_q` output IR_W: current decoded IR.
- `take_action` output N_CH: one-hot, held until accepted.
- `take_no_action` output N_CH: one-hot, single-cycle pulse.
- `overrun` output 1: sticky; an update was dropped while busy.
- `timeout_err` output 1: sticky; an action was abandoned.
- `parity_err` output 1: sticky; see Configuration.
- `cmd_count` output 16: saturating count of issued strobes.

## Operation
- Synchronizers:
  - Each toggle passes through `SYNC_STAGES` flops.
  - An edge is `sync_out != hist`. `hist` then updates every cycle.
  - During `reset`, `hist` loads `sync_out`, so no edge is seen on release regardless of toggle level.
- FSM states are IDLE, ISSUE, WAIT.
- IDLE:
  - On a uir edge: `ir_q <= ir_async`.
  - On a udr edge: `jdo <= sr_async`, latch channel `ch`, go to ISSUE.
    - `ch` is `ir_async` if a uir edge occurs in the same cycle, otherwise `ir_q`.
- ISSUE (one cycle):
  - Parity fail (macro on): set `parity_err`, go to IDLE, no strobe.
  - `jdo[ACT_BIT]==0`: pulse `take_no_action[ch]`, increment `cmd_count`, go to IDLE.
  - Otherwise: assert `take_action[ch]`, go to WAIT.
- WAIT:
  - `take_action[ch] & act_ready[ch]`: accept. Clear `take_action` next cycle, increment `cmd_count`, go to IDLE.
  - Wait counter reaches `TIMEOUT` (when nonzero): clear `take_action`, set `timeout_err`, go to IDLE. `cmd_count` is not incremented.
- Busy events:
  - A udr edge in ISSUE or WAIT is dropped and sets `overrun`. `jdo` is unchanged.
  - A uir edge in ISSUE or WAIT sets `ir_pend`. `ir_q <= ir_async` is applied on the first IDLE cycle, before decoding any same-cycle udr edge.
- Status:
  - `cmd_count` saturates at 16'hFFFF.
  - `clr_status` zeroes `overrun`, `timeout_err`, `parity_err` and `cmd_count`.
  - A set event in the same cycle as `clr_status` wins: the flag ends at 1 and the count at 1.
- Reset:
  - Every output resets to 0 and the FSM to IDLE.
  - Reset in WAIT drops `take_action` the next cycle with no flag.

## Timing
- Input toggle to edge detect: `SYNC_STAGES+1` cycles.
- Edge cycle E: `jdo` is valid at E+1 (state ISSUE).
- `take_action` / `take_no_action` are registered and assert at E+2.
- Handshake: transfer happens on the cycle where `take_action` and `act_ready` are both high. `take_action` is low the following cycle.
- `act_ready` high before E+2 has no effect.
- Timeout: `take_action` is high for exactly `TIMEOUT` cycles, then drops.
- Back-to-back no-action commands: minimum udr edge spacing of 2 cycles is accepted without overrun.
- All outputs come from flops. There is no combinational path from input to output.

## Configuration
- `LIMBUS_DBG_CMD_PARITY_EN` defined:
  - `jdo[DATA_W-1]` is the even-parity bit over `jdo[DATA_W-2:0]`.
  - A mismatch suppresses the strobe and sets `parity_err`.
- Undefined: no check is made, `parity_err` is tied to 0, and `jdo[DATA_W-1]` is ordinary data.

## Test plan
- IR=2'b01 via uir toggle, then udr with `sr_async[34]=0` -> one-cycle `take_no_action=4'b0010` at E+2, `cmd_count=1`.
- IR=2'b11, `sr[34]=1`, `act_ready[3]` raised 5 cycles after E+2 -> `take_action=4'b1000` for exactly 6 cycles, then 0, `cmd_count` increments.
- `TIMEOUT=8`, `act_ready=0` -> `take_action` high for 8 cycles, then `timeout_err=1`, `cmd_count` unchanged.
- Second udr toggle during WAIT -> `overrun=1`, `jdo` holds the first value. A uir toggle in the same window is applied after IDLE is re-entered.
- Macro on, `sr=38'h1_0000_0000` (bad parity) -> no strobe, `parity_err=1`. Then `clr_status` -> all flags 0.
- `reset` asserted in WAIT with toggles held at 1 -> outputs 0 next cycle, and no spurious command after release.
